alu_sequencer: RTL

Multi-cycle control unit for the 8-bit microprocessor. It fetches instruction bytes from instruction memory over a req/ack handshake, decodes them, and drives the ALU's 2-bit `ALUCtrl`. It also drives the register-file read/write addresses, write enable, write-source select and the program counter. It sits between instruction memory and the ALU8BIT/register-file datapath, as the producer of every ALU operation.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/instr_decode.sv | 30 +++
 rtl/alu_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcode/sub-op values, ALU control
// encodings (also used by ALU8BIT), sequencer state encoding, instruction fields.
package cpu_pkg;

  localparam int OP_MSB = 7;
  localparam int OP_LSB = 6;
  localparam int RD_MSB = 5;
  localparam int RD_LSB = 4;
  localparam int RS_MSB = 3;
  localparam int RS_LSB = 2;
  localparam int RT_MSB = 1;
  localparam int RT_LSB = 0;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SYS = 2'b11;

  localparam logic [1:0] SUB_NOP  = 2'b00;
  localparam logic [1:0] SUB_LDI  = 2'b01;
  localparam logic [1:0] SUB_JMP  = 2'b10;
  localparam logic [1:0] SUB_HALT = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_FETCH2,
    ST_HALT
  } state_t;

  // Never yields 11; the system opcode maps to SUB but is never issued to the ALU.
  function automatic logic [1:0] alu_ctrl_of(input logic [1:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_AND:  return ALU_AND;
      default: return ALU_SUB;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of the instruction register into fields and class flags.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [7:0] ir,
  output logic [1:0] rd,
  output logic [1:0] rs,
  output logic [1:0] rt,
  output logic [1:0] alu_op,
  output logic       is_alu,
  output logic       is_ldi,
  output logic       is_jmp,
  output logic       is_nop,
  output logic       is_halt
);

  logic [1:0] op;

  assign op      = ir[OP_MSB:OP_LSB];
  assign rd      = ir[RD_MSB:RD_LSB];
  assign rs      = ir[RS_MSB:RS_LSB];
  assign rt      = ir[RT_MSB:RT_LSB];
  assign alu_op  = alu_ctrl_of(op);
  assign is_alu  = (op != OP_SYS);
  assign is_nop  = (op == OP_SYS) && (rt == SUB_NOP);
  assign is_ldi  = (op == OP_SYS) && (rt == SUB_LDI);
  assign is_jmp  = (op == OP_SYS) && (rt == SUB_JMP);
  assign is_halt = (op == OP_SYS) && (rt == SUB_HALT);

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit: fetches over req/ack, decodes, and sequences the
// ALU and register file. All outputs are registered alongside the state.
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] imem_addr,
  output logic       imem_req,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic [1:0] rf_ra,
  output logic [1:0] rf_rb,
  output logic [1:0] rf_wa,
  output logic       rf_we,
  output logic       rf_wsel,
  output logic [7:0] imm,
  output logic [1:0] ALUCtrl,
  output logic       halted
);

  state_t     state;
  logic [7:0] pc;
  logic [7:0] ir;
  logic [1:0] rd, rs, rt, alu_op;
  logic       is_alu, is_ldi, is_jmp, is_nop, is_halt;

  instr_decode u_decode (
    .ir      (ir),
    .rd      (rd),
    .rs      (rs),
    .rt      (rt),
    .alu_op  (alu_op),
    .is_alu  (is_alu),
    .is_ldi  (is_ldi),
    .is_jmp  (is_jmp),
    .is_nop  (is_nop),
    .is_halt (is_halt)
  );

  // Outputs are set on the edge that enters a state, so they are valid for
  // the whole of that state and never depend combinationally on inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      ir        <= 8'h00;
      imem_addr <= RESET_PC;
      imem_req  <= 1'b0;
      rf_ra     <= 2'd0;
      rf_rb     <= 2'd0;
      rf_wa     <= 2'd0;
      rf_we     <= 1'b0;
      rf_wsel   <= 1'b0;
      imm       <= 8'h00;
      ALUCtrl   <= ALU_ADD;
      halted    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state     <= ST_FETCH;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_data;
            pc       <= pc + 8'd1;
            imem_req <= 1'b0;
            state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (is_alu) begin
            rf_ra   <= rs;
            rf_rb   <= rt;
            ALUCtrl <= alu_op;
            state   <= ST_EXEC;
          end else if (is_nop) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
            state     <= ST_FETCH;
          end else if (is_ldi || is_jmp) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
            state     <= ST_FETCH2;
          end else if (is_halt) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end
        end
        ST_EXEC: begin
          rf_we   <= 1'b1;
          rf_wa   <= rd;
          rf_wsel <= 1'b0;
          state   <= ST_WB;
        end
        ST_WB: begin
          rf_we     <= 1'b0;
          rf_wsel   <= 1'b0;
          rf_ra     <= 2'd0;
          rf_rb     <= 2'd0;
          ALUCtrl   <= ALU_ADD;
          imem_req  <= 1'b1;
          imem_addr <= pc;
          state     <= ST_FETCH;
        end
        ST_FETCH2: begin
          if (imem_ack) begin
            if (is_ldi) begin
              imm      <= imem_data;
              pc       <= pc + 8'd1;
              imem_req <= 1'b0;
              rf_we    <= 1'b1;
              rf_wa    <= rd;
              rf_wsel  <= 1'b1;
              state    <= ST_WB;
            end else begin
              // Jump target is fetched straight away; the request stays up.
              pc        <= imem_data;
              imem_addr <= imem_data;
              state     <= ST_FETCH;
            end
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
